// File: rtl/mac_checker.sv
// Receive-side MAC frame checker: parses start/DST/SRC/DATA/terminate blocks and flags errors.
// Optional destination-address filter enabled by defining MAC_CHECKER_ADDR_FILTER_EN.
module mac_checker_lane #(
  parameter logic [7:0] PAT      = 8'hAA,
  parameter logic [7:0] FCS      = 8'hC0,
  parameter bit         TAIL_FCS = 1'b0
) (
  input  logic [7:0] pend_byte,
  output logic       is_pat,
  output logic       tail_ok
);
  assign is_pat  = (pend_byte == PAT);
  assign tail_ok = TAIL_FCS ? (pend_byte == FCS) : (pend_byte == PAT);
endmodule

module mac_checker #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int          MIN_PAYLOAD       = 46,
  parameter int          MAX_PAYLOAD       = 1500,
  parameter logic [7:0]  START_CODE        = 8'hFB,
  parameter logic [7:0]  TERMINATE_CODE    = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE     = 8'h55,
  parameter logic [7:0]  SFD_CODE          = 8'hD5,
  parameter logic [7:0]  FCS_CODE          = 8'hC0,
  parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [47:0] DST_ADDR_MATCH    = 48'h0180C2000001
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_done,
  output logic                  o_frame_good,
  output logic [5:0]            o_err_flags,
  output logic [47:0]           o_dst_addr,
  output logic [47:0]           o_src_addr,
  output logic [15:0]           o_len_typ,
  output logic [15:0]           o_payload_bytes,
  output logic [15:0]           o_good_count,
  output logic [15:0]           o_bad_count,
  output logic                  o_addr_miss
);
  localparam int NUM_LANES = DATA_WIDTH/8;
  localparam int F_PRE = 0, F_FMT = 1, F_LEN = 2, F_FCS = 3, F_PAT = 4, F_ABT = 5;
  localparam logic [15:0] MIN_P = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_P = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, DST, SRC, DATA} state_t;

  state_t                         state;
  logic [NUM_LANES-1:0][7:0]      lane, pend;
  logic                           pend_vld;
  logic [15:0]                    cnt;
  logic [5:0]                     err;
  logic [47:0]                    dst_q, src_q;
  logic [15:0]                    len_q;
  logic [NUM_LANES-1:0]           pend_pat, pend_tail;
  logic                           is_ctl1, is_start, is_term, is_data, pre_ok, miss;
  logic                           end_frm;
  logic [5:0]                     end_flags;
  logic [15:0]                    end_cnt;

  assign lane = i_rx_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mac_checker_lane #(
      .PAT(DATA_CHAR_PATTERN), .FCS(FCS_CODE), .TAIL_FCS(g >= 4)
    ) u_lane (
      .pend_byte(pend[g]), .is_pat(pend_pat[g]), .tail_ok(pend_tail[g])
    );
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign is_ctl1  = (i_rx_ctrl == CTRL_WIDTH'(1));
  assign is_start = is_ctl1 && (lane[0] == START_CODE);
  assign is_term  = is_ctl1 && (lane[0] == TERMINATE_CODE);
  assign is_data  = (i_rx_ctrl == '0);

  always_comb begin
    pre_ok = (lane[NUM_LANES-1] == SFD_CODE);
    for (int i = 1; i < NUM_LANES-1; i++) pre_ok = pre_ok && (lane[i] == PREAMBLE_CODE);
  end

  // Decide whether the word being sampled closes the current frame, and with which flags.
  always_comb begin
    end_frm   = 1'b0;
    end_flags = err;
    end_cnt   = cnt;
    if (state != IDLE) begin
      if (is_start) begin
        end_frm = 1'b1;
        end_flags[F_ABT] = 1'b1;
      end else if (state == DATA && is_term) begin
        end_frm = 1'b1;
        if (pend_vld) begin
          end_cnt = sat_add(cnt, 16'd4);
          if (!(&pend_tail[3:0])) end_flags[F_PAT] = 1'b1;
          if (!(&pend_tail[7:4])) end_flags[F_FCS] = 1'b1;
          if (end_cnt < MIN_P || end_cnt > MAX_P) end_flags[F_LEN] = 1'b1;
        end else begin
          end_flags[F_FMT] = 1'b1;
          end_flags[F_LEN] = 1'b1;
        end
      end else if (!is_data) begin
        end_frm = 1'b1;
        end_flags[F_FMT] = 1'b1;
      end
    end
  end

`ifdef MAC_CHECKER_ADDR_FILTER_EN
  assign miss = (dst_q != DST_ADDR_MATCH);
`else
  logic unused_match;
  assign unused_match = ^DST_ADDR_MATCH;
  assign miss = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE; pend <= '0; pend_vld <= 1'b0; cnt <= '0; err <= '0;
      dst_q <= '0; src_q <= '0; len_q <= '0;
      o_frame_done <= 1'b0; o_frame_good <= 1'b0; o_err_flags <= '0;
      o_dst_addr <= '0; o_src_addr <= '0; o_len_typ <= '0; o_payload_bytes <= '0;
      o_good_count <= '0; o_bad_count <= '0; o_addr_miss <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_addr_miss  <= 1'b0;
      if (end_frm) begin
        o_frame_done    <= 1'b1;
        o_frame_good    <= (end_flags == '0) && !miss;
        o_err_flags     <= end_flags;
        o_addr_miss     <= miss;
        o_dst_addr      <= dst_q;
        o_src_addr      <= src_q;
        o_len_typ       <= len_q;
        o_payload_bytes <= end_cnt;
        if (!miss) begin
          if (end_flags == '0) o_good_count <= o_good_count + 16'd1;
          else                 o_bad_count  <= o_bad_count + 16'd1;
        end
        state    <= IDLE;
        pend_vld <= 1'b0;
      end
      // A start block always opens a new frame, even when it aborted the previous one.
      if (is_start) begin
        state    <= DST;
        err      <= pre_ok ? 6'd0 : 6'd1 << F_PRE;
        cnt      <= '0;
        pend_vld <= 1'b0;
      end else if (is_data) begin
        case (state)
          DST: begin
            dst_q        <= i_rx_data[47:0];
            src_q[15:0]  <= i_rx_data[63:48];
            state        <= SRC;
          end
          SRC: begin
            src_q[47:16] <= i_rx_data[31:0];
            len_q        <= i_rx_data[47:32];
            cnt          <= sat_add(cnt, 16'd2);
            if (lane[6] != DATA_CHAR_PATTERN || lane[7] != DATA_CHAR_PATTERN) err[F_PAT] <= 1'b1;
            state        <= DATA;
          end
          DATA: begin
            if (pend_vld) begin
              cnt <= sat_add(cnt, 16'd8);
              if (!(&pend_pat)) err[F_PAT] <= 1'b1;
            end
            pend     <= lane;
            pend_vld <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_checker.sv
// Scoreboard bench for mac_checker: directed frames push expectations, a monitor checks each done pulse.
module tb_mac_checker;
  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [63:0] i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic        o_frame_done, o_frame_good, o_addr_miss;
  logic [5:0]  o_err_flags;
  logic [47:0] o_dst_addr, o_src_addr;
  logic [15:0] o_len_typ, o_payload_bytes, o_good_count, o_bad_count;

  always #5 clk = ~clk;

  mac_checker dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_ctrl(i_rx_ctrl),
    .o_frame_done(o_frame_done), .o_frame_good(o_frame_good), .o_err_flags(o_err_flags),
    .o_dst_addr(o_dst_addr), .o_src_addr(o_src_addr), .o_len_typ(o_len_typ),
    .o_payload_bytes(o_payload_bytes), .o_good_count(o_good_count),
    .o_bad_count(o_bad_count), .o_addr_miss(o_addr_miss)
  );

  localparam logic [63:0] W_IDLE      = {8{8'h07}};
  localparam logic [63:0] W_START     = {8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [63:0] W_START_BAD = {8'hD5, {5{8'h55}}, 8'h00, 8'hFB};
  localparam logic [63:0] W_TERM      = {{7{8'h07}}, 8'hFD};
  localparam logic [63:0] W_DST       = {16'h5455, 48'h0180C2000001};
  localparam logic [63:0] W_DST_MISS  = {16'h5455, 48'h0180C2000002};
  localparam logic [63:0] W_SRC       = {16'hAAAA, 16'h8808, 32'h5A515253};
  localparam logic [63:0] W_AA        = {8{8'hAA}};
  localparam logic [63:0] W_LAST      = {{4{8'hC0}}, {4{8'hAA}}};
  localparam logic [63:0] W_LAST_BAD  = {32'h0, {4{8'hAA}}};

  typedef struct {
    logic        good;
    logic [5:0]  flags;
    logic [15:0] pay;
    logic        miss;
    logic [15:0] gc;
    logic [15:0] bc;
    logic        chk;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] mgc = 0, mbc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] flags, input logic [15:0] pay, input logic miss,
                      input logic chk);
    exp_t e;
    e.good = (flags == 6'd0) && !miss;
    if (!miss) begin
      if (e.good) mgc++;
      else        mbc++;
    end
    e.flags = flags; e.pay = pay; e.miss = miss; e.gc = mgc; e.bc = mbc; e.chk = chk;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_frame_done === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        check("frame_good", o_frame_good, e.good);
        check("err_flags", o_err_flags, e.flags);
        check("payload_bytes", o_payload_bytes, e.pay);
        check("addr_miss", o_addr_miss, e.miss);
        check("good_count", o_good_count, e.gc);
        check("bad_count", o_bad_count, e.bc);
        if (e.chk) begin
          check("dst_addr", o_dst_addr, 48'h0180C2000001);
          check("src_addr", o_src_addr, 48'h5A5152535455);
          check("len_typ", o_len_typ, 16'h8808);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [63:0] d);
    @(posedge clk); #1;
    i_rx_ctrl = c; i_rx_data = d;
  endtask

  task automatic frame(input logic [63:0] sw, input logic [63:0] dw, input logic [63:0] lw,
                       input int n_aa, input int bad);
    send(8'h01, sw);
    send(8'h00, dw);
    send(8'h00, W_SRC);
    for (int i = 0; i < n_aa; i++) send(8'h00, (i == bad) ? 64'd0 : W_AA);
    send(8'h00, lw);
    send(8'h01, W_TERM);
    send(8'hFF, W_IDLE);
    send(8'hFF, W_IDLE);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_done"}, o_frame_done, 0);
    check({nm, "_good"}, o_frame_good, 0);
    check({nm, "_flags"}, o_err_flags, 0);
    check({nm, "_dst"}, o_dst_addr, 0);
    check({nm, "_src"}, o_src_addr, 0);
    check({nm, "_len"}, o_len_typ, 0);
    check({nm, "_pay"}, o_payload_bytes, 0);
    check({nm, "_gc"}, o_good_count, 0);
    check({nm, "_bc"}, o_bad_count, 0);
    check({nm, "_miss"}, o_addr_miss, 0);
  endtask

  initial begin
    i_rx_ctrl = 8'hFF; i_rx_data = W_IDLE;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 i_rst_n = 1'b1;

    push(6'b000000, 16'd46, 1'b0, 1'b1);            // nominal
    frame(W_START, W_DST, W_LAST, 5, -1);
    push(6'b010000, 16'd46, 1'b0, 1'b1);            // one data word of zeros
    frame(W_START, W_DST, W_LAST, 5, 2);

    push(6'b000110, 16'd2, 1'b0, 1'b1);             // terminate right after SRC
    send(8'h01, W_START); send(8'h00, W_DST); send(8'h00, W_SRC);
    send(8'h01, W_TERM); send(8'hFF, W_IDLE); send(8'hFF, W_IDLE);

    push(6'b100000, 16'd10, 1'b0, 1'b1);            // abort, then complete frame
    push(6'b000000, 16'd46, 1'b0, 1'b1);
    send(8'h01, W_START); send(8'h00, W_DST); send(8'h00, W_SRC);
    send(8'h00, W_AA); send(8'h00, W_AA);
    frame(W_START, W_DST, W_LAST, 5, -1);

    push(6'b000001, 16'd46, 1'b0, 1'b1);            // bad preamble
    frame(W_START_BAD, W_DST, W_LAST, 5, -1);
    push(6'b001000, 16'd46, 1'b0, 1'b1);            // bad FCS lanes
    frame(W_START, W_DST, W_LAST_BAD, 5, -1);

    push(6'b000010, 16'd0, 1'b0, 1'b0);             // control word in SRC
    send(8'h01, W_START); send(8'h00, W_DST); send(8'hFF, W_IDLE);
    send(8'hFF, W_IDLE); send(8'hFF, W_IDLE);

    push(6'b000100, 16'd38, 1'b0, 1'b1);            // too short
    frame(W_START, W_DST, W_LAST, 4, -1);
    push(6'b000000, 16'd1494, 1'b0, 1'b1);          // longest legal at this granularity
    frame(W_START, W_DST, W_LAST, 186, -1);
    push(6'b000100, 16'd1502, 1'b0, 1'b1);          // too long
    frame(W_START, W_DST, W_LAST, 187, -1);

`ifdef MAC_CHECKER_ADDR_FILTER_EN
    push(6'b000000, 16'd46, 1'b1, 1'b0);
`else
    push(6'b000000, 16'd46, 1'b0, 1'b0);
`endif
    frame(W_START, W_DST_MISS, W_LAST, 5, -1);

    // reset asserted in the middle of a frame
    send(8'h01, W_START); send(8'h00, W_DST); send(8'h00, W_SRC);
    send(8'h00, W_AA); send(8'h00, W_AA);
    @(posedge clk); #1;
    i_rst_n = 1'b0; i_rx_ctrl = 8'hFF; i_rx_data = W_IDLE;
    mgc = 0; mbc = 0;
    @(negedge clk); check_zero("midrst_a");
    @(negedge clk); check_zero("midrst_b");
    @(posedge clk); #1 i_rst_n = 1'b1;

    push(6'b000000, 16'd46, 1'b0, 1'b1);
    frame(W_START, W_DST, W_LAST, 5, -1);

    repeat (10) @(negedge clk);
    check("scoreboard_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_checker.md
MAC_CHECKER -- requirements
Module: mac_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 64; rx data width, fixed at 64 (eight byte lanes, lane 0 = bits 7:0).
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8; one control bit per lane.
REQ-003 Parameter MIN_PAYLOAD, default 46; minimum legal payload byte count.
REQ-004 Parameter MAX_PAYLOAD, default 1500; maximum legal payload byte count.
REQ-005 Parameters START_CODE 8'hFB, TERMINATE_CODE 8'hFD, PREAMBLE_CODE 8'h55, SFD_CODE 8'hD5, FCS_CODE 8'hC0, DATA_CHAR_PATTERN 8'hAA, DST_ADDR_MATCH 48'h0180C2000001.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_rx_data  input  64  received data block.
REQ-009 i_rx_ctrl  input  8  per-lane control flag (1 = control character).
REQ-010 o_frame_done  output  1  one-cycle pulse at end of every frame (good, errored or aborted).
REQ-011 o_frame_good  output  1  valid with o_frame_done; 1 = no error flags set.
REQ-012 o_err_flags  output  6  valid with o_frame_done: [0] PREAMBLE, [1] FORMAT, [2] LENGTH, [3] FCS, [4] PATTERN, [5] ABORT.
REQ-013 o_dst_addr / o_src_addr  output  48 each; o_len_typ  output  16; o_payload_bytes  output  16; fields of the last completed frame.
REQ-014 o_good_count / o_bad_count  output  16 each; wrapping frame counters.
REQ-015 o_addr_miss  output  1  pulse with o_frame_done when the address filter rejects a frame.

Function
REQ-016 Start block: i_rx_ctrl==8'h01 and lane 0==START_CODE; lanes 1-6 SHALL equal PREAMBLE_CODE and lane 7 SFD_CODE, else PREAMBLE flag set (parsing continues).
REQ-017 FSM states IDLE, DST, SRC, DATA; IDLE -> DST on start block; all other words in IDLE are ignored.
REQ-018 DST word (ctrl 0): o_dst_addr <= lanes 0-5; lanes 6-7 held as src_addr[15:0]; -> SRC.
REQ-019 SRC word (ctrl 0): src_addr[47:16] <= lanes 0-3; o_len_typ <= bits 47:32; lanes 6-7 count as 2 payload bytes; -> DATA.
REQ-020 In DATA each ctrl-0 word is held in a one-word pending register; arrival of the next ctrl-0 word commits the pending word as 8 payload bytes.
REQ-021 Terminate block: ctrl==8'h01, lane 0==TERMINATE_CODE; pending word lanes 0-3 count as payload, lanes 4-7 SHALL equal FCS_CODE, else FCS flag; -> IDLE.
REQ-022 Terminate with no pending word: FORMAT and LENGTH flags set, frame ends.
REQ-023 Every payload byte SHALL equal DATA_CHAR_PATTERN, else PATTERN flag.
REQ-024 Payload counter 16-bit, saturating at 16'hFFFF; final count < MIN_PAYLOAD or > MAX_PAYLOAD sets LENGTH.
REQ-025 Any other nonzero ctrl word in DST/SRC/DATA: FORMAT flag, frame ends, -> IDLE.
REQ-026 Start block in DST/SRC/DATA: current frame ends with ABORT flag; new frame parsing begins same cycle (-> DST).
REQ-027 o_frame_done, o_frame_good, o_err_flags and all field outputs register in the cycle after the terminating word is sampled; o_frame_done high exactly one cycle.
REQ-028 o_good_count increments for good frames, o_bad_count for frames with any flag; both update in the o_frame_done cycle.

Reset
REQ-029 While i_rst_n==0: state IDLE, pending register, counters, all outputs 0; abandoned frame produces no o_frame_done.
REQ-030 After release, the first start block is parsed normally.

Configuration
REQ-031 MAC_CHECKER_ADDR_FILTER_EN defined: dst != DST_ADDR_MATCH gives o_frame_done, o_frame_good=0, o_addr_miss=1, err flags unchanged, neither counter increments.
REQ-032 MAC_CHECKER_ADDR_FILTER_EN undefined: no comparison, o_addr_miss constant 0.

Verification
REQ-033 Nominal frame: start, DST, SRC, 5 AA words, {C0x4,AAx4}, terminate -> done, good=1, flags 0, payload=46, dst=0180C2000001, src=5A5152535455, len_typ=8808, good_count=1.
REQ-034 Nominal frame with one data word all 8'h00 -> good=0, flags=6'b010000, bad_count=1.
REQ-035 Terminate directly after SRC word -> flags=6'b000110, payload=2.
REQ-036 Start block during DATA, then complete frame -> first done flags=6'b100000; second done good=1, payload=46.
REQ-037 i_rst_n low for 2 cycles mid-DATA -> all outputs 0, no done pulse; following nominal frame good, good_count=1.
REQ-038 Macro defined, DST word lanes 0-5 = 0180C2000002 -> done, addr_miss=1, good=0, both counters unchanged; macro undefined -> good=1.
